// File: rtl/fixed_requant_pkg.sv
// Shared arithmetic helpers and derived-size helpers for the fixed-point requantiser.
// All arithmetic is done on a 64-bit signed working width so the helpers serve any lane width.
package fixed_requant_pkg;

    localparam int WIDE_W = 64;
    localparam logic [WIDE_W-1:0] WIDE_ONE = 64'd1;

    typedef logic signed [WIDE_W-1:0] wide_t;

    // Result of a clamp: the (possibly clamped) value and whether clamping happened.
    typedef struct packed {
        logic  sat;
        wide_t val;
    } sat_result_t;

    // Number of beats that make up one tensor.
    function automatic int calc_beats(input int tsd0, input int pd0, input int tsd1, input int pd1);
        return (tsd0 / pd0) * (tsd1 / pd1);
    endfunction

    // Width able to hold a saturation count from 0 up to every element of a tensor.
    function automatic int calc_cnt_w(input int tsd0, input int tsd1);
        return $clog2(tsd0 * tsd1 + 1);
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Drop d fractional bits with round-half-to-even. d == 0 passes x through.
    function automatic wide_t round_half_even(input wide_t x, input int d);
        logic [WIDE_W-1:0] mask;
        logic [5:0]        lsb_idx;
        logic [5:0]        guard_idx;
        logic              incr;
        wide_t             res;
        res = x;
        if (d > 0) begin
            lsb_idx   = 6'(d);
            guard_idx = 6'(d - 1);
            // Sticky covers every bit below the guard bit; empty when d == 1.
            mask      = (WIDE_ONE << guard_idx) - WIDE_ONE;
            incr      = x[guard_idx] & ((|(x & mask)) | x[lsb_idx]);
            res       = (x >>> d) + wide_t'({{(WIDE_W-1){1'b0}}, incr});
        end
        return res;
    endfunction

    // Clamp a value to the range of an out_w-bit signed word.
    function automatic sat_result_t saturate(input wide_t v, input int out_w);
        wide_t       hi;
        wide_t       lo;
        sat_result_t res;
        hi      = wide_t'((WIDE_ONE << (out_w - 1)) - WIDE_ONE);
        lo      = -hi - wide_t'(WIDE_ONE);
        res.sat = 1'b1;
        res.val = v;
        if (v > hi) begin
            res.val = hi;
        end else if (v < lo) begin
            res.val = lo;
        end else begin
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_requant_lane.sv
// One lane of the requantiser: rounding (feeds the stage-1 register) and
// saturation (fed from the stage-1 register). Purely combinational.
module fixed_requant_lane
    import fixed_requant_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 3,
    localparam int D       = IN_FRAC - OUT_FRAC,
    localparam int R_W     = IN_W - D + 1
) (
    input  logic [IN_W-1:0]  i_x,
    output logic [R_W-1:0]   o_round,
    input  logic [R_W-1:0]   i_round,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    wide_t w_x_wide;
    wide_t w_round_wide;
    wide_t w_r_wide;

    assign w_x_wide     = {{(WIDE_W-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_round_wide = round_half_even(w_x_wide, D);
    assign o_round      = w_round_wide[R_W-1:0];

    // Registered rounded value, widened again for the clamp.
    assign w_r_wide     = {{(WIDE_W-R_W){i_round[R_W-1]}}, i_round};

    // Rounding may carry one bit beyond IN_W-D, so the clamp is only skipped
    // when that full rounded width already fits in the output word.
    if (R_W <= OUT_W) begin : g_extend
        assign o_data = w_r_wide[OUT_W-1:0];
        assign o_sat  = 1'b0;
        logic w_unused_ext;
        assign w_unused_ext = ^{w_round_wide[WIDE_W-1:R_W], w_r_wide[WIDE_W-1:OUT_W]};
    end else begin : g_clamp
        sat_result_t w_sat_res;
        assign w_sat_res = saturate(w_r_wide, OUT_W);
        assign o_data    = w_sat_res.val[OUT_W-1:0];
        assign o_sat     = w_sat_res.sat;
        logic w_unused_clamp;
        assign w_unused_clamp = ^{w_round_wide[WIDE_W-1:R_W], w_sat_res.val[WIDE_W-1:OUT_W]};
    end

endmodule

// File: rtl/fixed_requant_pipe.sv
// Streaming requantiser: round-half-even then saturate in a two-stage
// valid/ready pipeline, with a per-tensor saturation counter.
module fixed_requant_pipe
    import fixed_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0        = 16,
    parameter int DATA_IN_0_PRECISION_1        = 6,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0  = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1  = 1,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = DATA_IN_0_TENSOR_SIZE_DIM_0,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = DATA_IN_0_TENSOR_SIZE_DIM_1,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
    parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1,
    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
    localparam int CNT_W = calc_cnt_w(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [P],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [P],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic [CNT_W-1:0]                  sat_count,
    output logic                              sat_count_valid
);

    localparam int IN_W   = DATA_IN_0_PRECISION_0;
    localparam int OUT_W  = DATA_OUT_0_PRECISION_0;
    localparam int D      = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    localparam int R_W    = IN_W - D + 1;
    localparam int BEATS  = calc_beats(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_PARALLELISM_DIM_0,
                                       DATA_IN_0_TENSOR_SIZE_DIM_1, DATA_IN_0_PARALLELISM_DIM_1);
    localparam int BEAT_W = calc_idx_w(BEATS);

    // Parameter sanity checks, evaluated at elaboration.
    if (DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0 ||
        DATA_OUT_0_TENSOR_SIZE_DIM_1 != DATA_IN_0_TENSOR_SIZE_DIM_1 ||
        DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0 ||
        DATA_OUT_0_PARALLELISM_DIM_1 != DATA_IN_0_PARALLELISM_DIM_1) begin : g_bad_shape
        $error("fixed_requant_pipe: output tensor shape must match input tensor shape");
    end
    if (D < 0) begin : g_bad_frac
        $error("fixed_requant_pipe: output fractional bits exceed input fractional bits");
    end
    if ((DATA_IN_0_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0) != 0 ||
        (DATA_IN_0_TENSOR_SIZE_DIM_1 % DATA_IN_0_PARALLELISM_DIM_1) != 0) begin : g_bad_par
        $error("fixed_requant_pipe: parallelism must divide tensor size");
    end

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_out_fire;
    logic w_last_beat;

    // Lane datapath
    logic [R_W-1:0]   w_round     [P];
    logic [OUT_W-1:0] w_lane_data [P];
    logic [P-1:0]     w_lane_sat;

    // Pipeline state
    logic             r_s1_valid;
    logic [R_W-1:0]   r_s1_round  [P];
    logic             r_s2_valid;
    logic [OUT_W-1:0] r_s2_data   [P];
    logic [P-1:0]     r_s2_sat;

    // Saturation accounting
    logic [BEAT_W-1:0] r_beat;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_sat_count;
    logic              r_sat_count_valid;
    logic [CNT_W-1:0]  w_pop;

    assign w_s2_adv        = !r_s2_valid || data_out_0_ready;
    assign w_s1_adv        = !r_s1_valid || w_s2_adv;
    assign data_in_0_ready = w_s1_adv;
    assign w_out_fire      = r_s2_valid && data_out_0_ready;
    assign w_last_beat     = (r_beat == BEAT_W'(BEATS - 1));

    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        fixed_requant_lane #(
            .IN_W     (IN_W),
            .IN_FRAC  (DATA_IN_0_PRECISION_1),
            .OUT_W    (OUT_W),
            .OUT_FRAC (DATA_OUT_0_PRECISION_1)
        ) u_lane (
            .i_x     (data_in_0[gi]),
            .o_round (w_round[gi]),
            .i_round (r_s1_round[gi]),
            .o_data  (w_lane_data[gi]),
            .o_sat   (w_lane_sat[gi])
        );
        assign data_out_0[gi] = r_s2_data[gi];
    end

    // Stage 1: capture rounded lanes whenever the stage can move.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_s1_round[i] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= data_in_0_valid;
            if (data_in_0_valid) begin
                for (int i = 0; i < P; i++) begin
                    r_s1_round[i] <= w_round[i];
                end
            end
        end
    end

    // Stage 2: capture saturated lanes; holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sat   <= '0;
            for (int i = 0; i < P; i++) begin
                r_s2_data[i] <= '0;
            end
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sat <= w_lane_sat;
                for (int i = 0; i < P; i++) begin
                    r_s2_data[i] <= w_lane_data[i];
                end
            end
        end
    end

    // Number of lanes that clamped in the beat currently on the output.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < P; i++) begin
            w_pop = w_pop + CNT_W'(r_s2_sat[i]);
        end
    end

    // Per-tensor saturation count; the last beat's clamps close the tensor they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat            <= '0;
            r_acc             <= '0;
            r_sat_count       <= '0;
            r_sat_count_valid <= 1'b0;
        end else begin
            r_sat_count_valid <= 1'b0;
            if (w_out_fire) begin
                if (w_last_beat) begin
                    r_sat_count       <= r_acc + w_pop;
                    r_sat_count_valid <= 1'b1;
                    r_acc             <= '0;
                    r_beat            <= '0;
                end else begin
                    r_acc  <= r_acc + w_pop;
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    assign data_out_0_valid = r_s2_valid;
    assign sat_count        = r_sat_count;
    assign sat_count_valid  = r_sat_count_valid;

endmodule

// File: tb/tb_fixed_requant_pipe.sv
// Directed bench for fixed_requant_pipe (16/6 -> 8/3, one lane, 8-beat tensors).
module tb_fixed_requant_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int P     = 1;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IN_W-1:0]  data_in_0 [P];
    logic             data_in_0_valid = 1'b0;
    logic             data_in_0_ready;
    logic [OUT_W-1:0] data_out_0 [P];
    logic             data_out_0_valid;
    logic             data_out_0_ready = 1'b1;
    logic [CNT_W-1:0] sat_count;
    logic             sat_count_valid;

    always #5 clk = ~clk;

    fixed_requant_pipe #(
        .DATA_IN_0_PRECISION_0       (16),
        .DATA_IN_0_PRECISION_1       (6),
        .DATA_IN_0_TENSOR_SIZE_DIM_0 (8),
        .DATA_IN_0_TENSOR_SIZE_DIM_1 (1),
        .DATA_IN_0_PARALLELISM_DIM_0 (1),
        .DATA_IN_0_PARALLELISM_DIM_1 (1),
        .DATA_OUT_0_PRECISION_0      (8),
        .DATA_OUT_0_PRECISION_1      (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .sat_count        (sat_count),
        .sat_count_valid  (sat_count_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int v;
        bit s;
        int acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   exp_sat_q[$];
    int   cur_v = 0;
    bit   cur_s = 1'b0;
    bit   lat_mode = 1'b0;
    bit   ready_rand = 1'b0;
    bit   ready_val = 1'b1;
    int   cyc = 0;
    int   m_acc = 0;
    int   m_beat = 0;
    int   n_out = 0;
    bit   prev_stall = 1'b0;
    logic signed [OUT_W-1:0] prev_data = '0;

    // Reference requantiser: floor-divide by 8, then resolve the remainder.
    function automatic void ref_requant(input int x, output int v, output bit s);
        int q;
        int rem;
        q   = x >>> 3;
        rem = x - q * 8;
        if (rem > 4) q = q + 1;
        else if (rem == 4 && (q % 2) != 0) q = q + 1;
        s = 1'b1;
        if (q > 127) v = 127;
        else if (q < -128) v = -128;
        else begin
            v = q;
            s = 1'b0;
        end
    endfunction

    // Downstream ready: fixed value or random, applied mid-cycle.
    initial forever begin
        @(posedge clk);
        #2;
        data_out_0_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Monitor: sampled on the falling edge, scoreboard of transfers and sat pulses.
    initial forever begin
        exp_t e;
        int   es;
        @(negedge clk);
        cyc++;
        if (sat_count_valid) begin
            if (exp_sat_q.size() > 0) begin
                es = exp_sat_q.pop_front();
                $display("sat_count pulse: got %0d expected %0d", sat_count, es);
                check("sat_count", sat_count, es);
            end else begin
                check("sat_pulse_unexpected", sat_count_valid, 0);
            end
        end
        if (prev_stall && rst) check("hold_stable", $signed(data_out_0[0]), prev_data);
        prev_stall = rst && data_out_0_valid && !data_out_0_ready;
        prev_data  = data_out_0[0];
        if (!rst) begin
            exp_q.delete();
            m_acc  = 0;
            m_beat = 0;
        end else begin
            if (data_out_0_valid && data_out_0_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", data_out_0_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    $display("out %0d: data=%0d expected=%0d", n_out, $signed(data_out_0[0]), e.v);
                    check("out_data", $signed(data_out_0[0]), e.v);
                    if (lat_mode) check("latency", cyc - e.acc_cyc, 2);
                    m_acc = m_acc + int'(e.s);
                    if (m_beat == 7) begin
                        exp_sat_q.push_back(m_acc);
                        m_acc  = 0;
                        m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end
            if (data_in_0_valid && data_in_0_ready) exp_q.push_back('{cur_v, cur_s, cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) for it to be accepted.
    task automatic send_beat(input int x, input int v, input bit s);
        int t;
        t = 0;
        data_in_0[0]    = 16'(x);
        cur_v           = v;
        cur_s           = s;
        data_in_0_valid = 1'b1;
        @(negedge clk);
        while (!data_in_0_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("accept", data_in_0_ready, 1);
        @(posedge clk);
        #1;
        data_in_0_valid = 1'b0;
    endtask

    task automatic send_ref(input int x);
        int v;
        bit s;
        ref_requant(x, v, s);
        send_beat(x, v, s);
    endtask

    // Wait (bounded) for a sat_count pulse, check its value and one-cycle width.
    task automatic wait_sat(input string tag, input int expv);
        int t;
        t = 0;
        @(negedge clk);
        while (!sat_count_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        check({tag, "_valid"}, sat_count_valid, 1);
        check(tag, sat_count, expv);
        @(negedge clk);
        check({tag, "_pulse_width"}, sat_count_valid, 0);
        tick();
    endtask

    // Let every accepted beat leave the pipe.
    task automatic drain();
        int t;
        t          = 0;
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        @(negedge clk);
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        tick();
    endtask

    initial begin
        int x;
        logic [15:0] r16;
        data_in_0[0] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", data_out_0_valid, 0);
        check("rst_data_out", data_out_0[0], 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_sat_valid", sat_count_valid, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_idle", data_in_0_ready, 1);
        tick();

        // Test 1: ties to even, two-cycle latency
        lat_mode = 1'b1;
        send_beat(20, 2, 0);
        send_beat(28, 4, 0);
        send_beat(-20, -2, 0);
        send_beat(12, 2, 0);

        // Test 2: extremes saturate; tensor closes with two saturations
        send_beat(32767, 127, 1);
        send_beat(-32768, -128, 1);
        send_beat(0, 0, 0);
        send_beat(8, 1, 0);
        wait_sat("t2_sat_count", 2);
        drain();
        lat_mode = 1'b0;

        // Test 3: downstream stall with three beats offered
        ready_val = 1'b0;
        fork
            begin
                send_beat(300, 38, 0);
                send_beat(100, 12, 0);
                send_beat(-100, -12, 0);
            end
            begin
                repeat (3) @(negedge clk);
                check("t3_in_ready_low", data_in_0_ready, 0);
                check("t3_out_valid", data_out_0_valid, 1);
                check("t3_out_held", $signed(data_out_0[0]), 38);
                repeat (2) @(negedge clk);
                check("t3_in_ready_still_low", data_in_0_ready, 0);
                tick();
                ready_val = 1'b1;
            end
        join
        drain();

        // Test 4: random traffic against the reference model
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            if ($urandom_range(0, 1) == 1) begin
                x = int'($urandom_range(0, 2400)) - 1200;
            end else begin
                r16 = 16'($urandom);
                x   = int'($signed(r16));
            end
            send_ref(x);
        end
        drain();

        // Test 5: reset mid-tensor discards the partial tensor
        rst = 1'b0;
        tick();
        rst = 1'b1;
        send_beat(32767, 127, 1);
        send_beat(32767, 127, 1);
        send_beat(40, 5, 0);
        send_beat(44, 6, 0);
        send_beat(52, 6, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t5_out_valid_after_rst", data_out_0_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_sat_pulse", sat_count_valid, 0);
        end
        tick();
        send_beat(-32768, -128, 1);
        send_beat(5000, 127, 1);
        send_beat(16, 2, 0);
        send_beat(1016, 127, 0);
        send_beat(1020, 127, 1);
        send_beat(-1028, -128, 0);
        send_beat(-1027, -128, 0);
        send_beat(7, 1, 0);
        wait_sat("t5_sat_count", 3);

        // Test 6: last beat saturates with three already counted
        send_beat(32767, 127, 1);
        send_beat(-32768, -128, 1);
        send_beat(-1029, -128, 1);
        send_beat(36, 4, 0);
        send_beat(44, 6, 0);
        send_beat(-4, 0, 0);
        send_beat(3, 0, 0);
        send_beat(1021, 127, 1);
        wait_sat("t6_sat_count", 4);
        send_beat(0, 0, 0);
        send_beat(8, 1, 0);
        send_beat(16, 2, 0);
        send_beat(-8, -1, 0);
        send_beat(24, 3, 0);
        send_beat(-16, -2, 0);
        send_beat(4, 0, 0);
        send_beat(12, 2, 0);
        wait_sat("t6_next_sat_count", 0);
        drain();
        check("sat_queue_empty", exp_sat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
